ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: EX_Stage

---
 rtl/ex_pkg.sv | 59 +++++
 rtl/Mul_Iter.sv | 53 +++++
 rtl/ex_stage.sv | 127 ++++++++++++
 tb/tb_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU op codes, DMEM access codes, EX FSM states and the
// EX/MEM bubble. Also imported by the ID and MEM stages.
package ex_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  localparam logic [1:0] ACC_NOAC = 2'd0;
  localparam logic [1:0] ACC_BYTE = 2'd1;
  localparam logic [1:0] ACC_HALF = 2'd2;
  localparam logic [1:0] ACC_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [4:0]  reg_addr;
    logic [31:0] alu_data;
    logic [31:0] write_data;
  } exmem_t;

  localparam exmem_t EXMEM_BUBBLE = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_read:   ACC_NOAC,
    mem_write:  ACC_NOAC,
    reg_addr:   5'd0,
    alu_data:   32'd0,
    write_data: 32'd0
  };

  // Single-cycle ALU; MUL and the unused codes 6-7 give 0 here.
  function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/Mul_Iter.sv
// Iterative shift-add multiplier, 32 iterations, low 32 product bits (sign-agnostic).
// Only built when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module Mul_Iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc_q;
  logic [4:0]  count_q;
  logic        busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 32'd0;
      count_q <= 5'd0;
      busy_q  <= 1'b0;
    end else if (abort) begin
      busy_q  <= 1'b0;
      count_q <= 5'd0;
    end else if (start) begin
      a_q     <= a;
      b_q     <= b;
      acc_q   <= 32'd0;
      count_q <= 5'd0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q     <= a_q << 1;
      b_q     <= b_q >> 1;
      count_q <= count_q + 5'd1;
      if (count_q == 5'd31) busy_q <= 1'b0;
    end
  end

  // done flags the final iteration; product is valid from the following cycle.
  assign busy    = busy_q;
  assign done    = busy_q && (count_q == 5'd31);
  assign product = acc_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: ALU plus EX/MEM pipeline register. Defining EX_MUL_EN adds an
// iterative MUL that stalls upstream while it runs; otherwise MUL returns 0.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        ALUSrc_i,
  input  logic        flush_i,
  input  logic [1:0]  MemRead_i,
  input  logic [1:0]  MemWrite_i,
  input  logic [2:0]  ALUOp_i,
  input  logic [4:0]  RegAddr_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] Imm_i,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [1:0]  MemRead_o,
  output logic [1:0]  MemWrite_o,
  output logic [4:0]  RegAddr_o,
  output logic [31:0] ALUdata_o,
  output logic [31:0] WriteData_o,
  output logic        stall_o,
  output ex_state_e   state_o
);

  logic [31:0] op_b;
  exmem_t      issue_w;
  exmem_t      exmem_q;

  assign op_b = ALUSrc_i ? Imm_i : RS2data_i;

  always_comb begin
    issue_w = '{
      reg_write:  RegWrite_i,
      mem_to_reg: MemToReg_i,
      mem_read:   MemRead_i,
      mem_write:  MemWrite_i,
      reg_addr:   RegAddr_i,
      alu_data:   alu_calc(ALUOp_i, RS1data_i, op_b),
      write_data: RS2data_i
    };
  end

`ifdef EX_MUL_EN
  ex_state_e   state_q;
  exmem_t      held_q;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;

  // Flush wins over a MUL issue; DONE never re-detects the still-held MUL.
  assign mul_start = (state_q == ST_IDLE) && (ALUOp_i == ALU_MUL) && !flush_i;
  assign stall_o   = mul_start || mul_busy;
  assign state_o   = state_q;

  Mul_Iter u_mul (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (mul_start),
    .abort  (flush_i),
    .a      (RS1data_i),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      exmem_q <= EXMEM_BUBBLE;
      held_q  <= EXMEM_BUBBLE;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      exmem_q <= EXMEM_BUBBLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ALUOp_i == ALU_MUL) begin
            held_q  <= issue_w;
            exmem_q <= EXMEM_BUBBLE;
            state_q <= ST_BUSY;
          end else begin
            exmem_q <= issue_w;
          end
        end
        ST_BUSY: begin
          exmem_q <= EXMEM_BUBBLE;
          if (mul_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          exmem_q          <= held_q;
          exmem_q.alu_data <= mul_product;
          state_q          <= ST_IDLE;
        end
        default: begin
          exmem_q <= EXMEM_BUBBLE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`else
  assign stall_o = 1'b0;
  assign state_o = ST_IDLE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        exmem_q <= EXMEM_BUBBLE;
    else if (flush_i) exmem_q <= EXMEM_BUBBLE;
    else              exmem_q <= issue_w;
  end
`endif

  assign RegWrite_o  = exmem_q.reg_write;
  assign MemToReg_o  = exmem_q.mem_to_reg;
  assign MemRead_o   = exmem_q.mem_read;
  assign MemWrite_o  = exmem_q.mem_write;
  assign RegAddr_o   = exmem_q.reg_addr;
  assign ALUdata_o   = exmem_q.alu_data;
  assign WriteData_o = exmem_q.write_data;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: randomized instruction stream against an arithmetic model,
// expected EX/MEM contents queued by the driver and checked by a per-cycle monitor.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int W = 75;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemToReg_i, ALUSrc_i, flush_i;
  logic [1:0]  MemRead_i, MemWrite_i;
  logic [2:0]  ALUOp_i;
  logic [4:0]  RegAddr_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i;
  logic        RegWrite_o, MemToReg_o;
  logic [1:0]  MemRead_o, MemWrite_o;
  logic [4:0]  RegAddr_o;
  logic [31:0] ALUdata_o, WriteData_o;
  logic        stall_o;
  ex_state_e   state_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;
  logic [W-1:0] mon_act, mon_exp;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .ALUSrc_i(ALUSrc_i), .flush_i(flush_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .RegAddr_i(RegAddr_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .RegAddr_o(RegAddr_o), .ALUdata_o(ALUdata_o),
    .WriteData_o(WriteData_o), .stall_o(stall_o), .state_o(state_o)
  );

  function automatic logic [W-1:0] pack(input logic rw, input logic m2r, input logic [1:0] mr,
                                         input logic [1:0] mw, input logic [4:0] addr,
                                         input logic [31:0] alu, input logic [31:0] wd);
    return {rw, m2r, mr, mw, addr, alu, wd};
  endfunction

  function automatic logic [W-1:0] outputs_now();
    return {RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, RegAddr_o, ALUdata_o, WriteData_o};
  endfunction

  // Reference arithmetic; MUL is the plain 32-bit product when the multiplier exists.
  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
      3'd5: r = a * b;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: the register loaded at each edge must match the next queued entry.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      mon_act = outputs_now();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL exmem_underflow act=%h exp=<none>", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("exmem", mon_act, mon_exp);
      end
    end
  end

  task automatic apply(input logic [2:0] op, input logic src, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic rw,
                       input logic m2r, input logic [1:0] mr, input logic [1:0] mw,
                       input logic [4:0] addr, input logic fl);
    rst_i = 1'b0;
    ALUOp_i = op; ALUSrc_i = src; RS1data_i = rs1; RS2data_i = rs2; Imm_i = imm;
    RegWrite_i = rw; MemToReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    RegAddr_i = addr; flush_i = fl;
  endtask

  task automatic do_single(input logic [2:0] op, input logic src, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm, input logic rw,
                           input logic m2r, input logic [1:0] mr, input logic [1:0] mw,
                           input logic [4:0] addr, input logic fl);
    @(negedge clk);
    apply(op, src, rs1, rs2, imm, rw, m2r, mr, mw, addr, fl);
    mon_on = 1'b1;
    if (fl) exp_q.push_back('0);
    else exp_q.push_back(pack(rw, m2r, mr, mw, addr, model_alu(op, rs1, src ? imm : rs2), rs2));
    #1;
    check("stall_single", W'(stall_o), W'(1'b0));
  endtask

`ifdef EX_MUL_EN
  // MUL held for n cycles; 34 cycles is a complete multiply, fl_last flushes the last one.
  task automatic do_mul(input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic rw, input logic [4:0] addr,
                        input int n, input logic fl_last);
    logic fl;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fl = fl_last && (i == n - 1);
      apply(3'd5, src, rs1, rs2, imm, rw, 1'b0, 2'd0, 2'd0, addr, fl);
      mon_on = 1'b1;
      if (i == 33 && !fl)
        exp_q.push_back(pack(rw, 1'b0, 2'd0, 2'd0, addr, model_alu(3'd5, rs1, src ? imm : rs2), rs2));
      else
        exp_q.push_back('0);
      #1;
      if (!fl) check("stall_mul", W'(stall_o), W'(i < 33));
    end
  endtask
`endif

  // Reset asserted mid-cycle with an ADD presented: bubble and IDLE without any edge.
  task automatic reset_pulse();
    @(negedge clk);
    apply(3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd9, 1'b0);
    rst_i = 1'b1;
    #1;
    check("reset_async_out", outputs_now(), '0);
    check("reset_state", W'(state_o), W'(ST_IDLE));
    check("reset_stall", W'(stall_o), W'(1'b0));
    exp_q.push_back('0);
  endtask

  initial begin
    logic [2:0] op;
    logic       fl;
    apply(3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 1'b0);
    rst_i = 1'b1;
    #3;
    check("reset_init_out", outputs_now(), '0);
    check("reset_init_state", W'(state_o), W'(ST_IDLE));

    // ADD with immediate, then SLT signed and SUB wrap.
    do_single(3'd0, 1'b1, 32'd5, 32'd100, 32'd7, 1'b1, 1'b0, 2'd0, 2'd0, 5'd3, 1'b0);
    do_single(3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd4, 1'b0);
    do_single(3'd1, 1'b0, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd5, 1'b0);
    do_single(3'd2, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0, 1'b1, 2'd3, 2'd0, 5'd6, 1'b0);
    do_single(3'd3, 1'b1, 32'h0000_00F0, 32'hABCD_0000, 32'h0F00_000F, 1'b0, 1'b0, 2'd0, 2'd2, 5'd7, 1'b0);
    do_single(3'd6, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 2'd1, 2'd1, 5'd8, 1'b0);
    do_single(3'd7, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd8, 1'b0);
    do_single(3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd2, 1'b1);
    // Flush simultaneous with a MUL issue: flush wins and no stall.
    do_single(3'd5, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd1, 1'b1);

`ifdef EX_MUL_EN
    do_mul(1'b0, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd10, 34, 1'b0);
    do_mul(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd11, 34, 1'b0);
    do_mul(1'b1, 32'd12345, 32'd77, 32'hFFFF_FFF9, 1'b1, 5'd12, 34, 1'b0);
    // Flush in BUSY: no result ever appears, next ADD is single-cycle.
    do_mul(1'b0, 32'd6, 32'd7, 32'd0, 1'b1, 5'd13, 12, 1'b1);
    do_single(3'd0, 1'b0, 32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd14, 1'b0);
    do_mul(1'b0, 32'd6, 32'd7, 32'd0, 1'b1, 5'd13, 34, 1'b1);
    // Reset in BUSY, then an ADD completes in one cycle.
    do_mul(1'b0, 32'd5, 32'd9, 32'd0, 1'b1, 5'd15, 15, 1'b0);
    reset_pulse();
    do_single(3'd0, 1'b1, 32'd20, 32'd1, 32'd22, 1'b1, 1'b0, 2'd0, 2'd0, 5'd16, 1'b0);
`else
    do_single(3'd5, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd10, 1'b0);
`endif

    // Reset right after a live result: outputs return to bubble with no edge.
    do_single(3'd0, 1'b0, 32'd40, 32'd2, 32'd0, 1'b1, 1'b1, 2'd3, 2'd0, 5'd31, 1'b0);
    reset_pulse();

    repeat (80) begin
      op = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 9) == 0);
`ifdef EX_MUL_EN
      if (op == 3'd5 && !fl) begin
        if ($urandom_range(0, 3) == 0)
          do_mul(1'($urandom_range(0, 1)), rand_val(), rand_val(), rand_val(), 1'b1,
                 5'($urandom_range(0, 31)), $urandom_range(2, 34), 1'b1);
        else
          do_mul(1'($urandom_range(0, 1)), rand_val(), rand_val(), rand_val(), 1'b1,
                 5'($urandom_range(0, 31)), 34, 1'b0);
      end else
`endif
      do_single(op, 1'($urandom_range(0, 1)), rand_val(), rand_val(), rand_val(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), fl);
    end

    @(posedge clk);
    #3;
    mon_on = 1'b0;
    check("queue_drain", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
